lift_motion_ctrl: RTL and testbench
===================================

Name: lift_motion_ctrl

Overview:
Single-lift controller FSM. It is the initiator on the door-timer interface: it drives Enable_counter to the door-open timer and consumes count_over from it. It latches floor requests, moves the car one floor at a time using an internal travel timer, and opens the door at each requested floor until the external timer reports expiry. It sits between the floor-button inputs and the motor/door actuators.

Parameters:
NUM_FLOORS, 8, number of floors (2..16); floors are numbered 0..NUM_FLOORS-1.
FLOOR_W, 3, width of floor index; must satisfy 2^FLOOR_W >= NUM_FLOORS.
TRAVEL_CYCLES, 20, Clock cycles to move one floor (>=2).

Ports:
Clock  in  1  system clock; all logic is posedge.
Reset_n  in  1  asynchronous, active-low reset.
Floor_req  in  NUM_FLOORS  level/pulse request per floor; sampled every cycle.
count_over  in  1  door-timer expiry from the external timer.
Enable_counter  out  1  door-timer enable; held high for the whole door-open interval.
Current_floor  out  FLOOR_W  floor the car is at or last passed.
Motor_up  out  1  car moving up.
Motor_down  out  1  car moving down.
Door_open  out  1  door open.
Req_pending  out  NUM_FLOORS  latched, not-yet-served requests.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Current_floor=0; Req_pending=0; travel counter=0; Motor_up=Motor_down=Door_open=Enable_counter=0. Up-direction flag = 1.
- Request latch: Req_pending[i] <= Req_pending[i] | Floor_req[i] each cycle. A bit is cleared on entry to DOOR_OPEN at that floor. Set wins over clear only when Floor_req[i] is high in the DOOR_OPEN entry cycle at floor i; see the optional feature for that case.
- ahead = any pending bit above Current_floor when direction is up, or below it when direction is down. behind = same test in the opposite direction.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_CLOSE.
- IDLE:
  - If the pending bit at Current_floor is set: go to DOOR_OPEN.
  - Else if ahead: move in the current direction.
  - Else if behind: flip direction and move.
  - Else: stay in IDLE.
- MOVE_x:
  - Motor output high; travel counter counts 0..TRAVEL_CYCLES-1.
  - At terminal count: Current_floor ±1 and the counter clears.
  - If the new floor is pending: go to DOOR_OPEN; motor drops the same edge.
  - Else if still ahead: keep moving.
  - Else: go to IDLE.
  - Current_floor never leaves 0..NUM_FLOORS-1. A MOVE is never entered toward a wall.
- DOOR_OPEN:
  - Door_open=1 and Enable_counter=1, registered from the state.
  - Wait for count_over=1, then go to DOOR_CLOSE.
- DOOR_CLOSE:
  - Exactly one cycle with Enable_counter=0 and Door_open=0.
  - Guarantees at least one timer negedge with enable low, so the timer clears temp and count_over.
  - Then go to IDLE.
- Handshake rules:
  - Enable_counter never rises within 1 cycle of falling.
  - count_over is ignored outside DOOR_OPEN.
  - A count_over stuck high at DOOR_OPEN entry is ignored for the first cycle (stale guard).
- Motor_up and Motor_down are never high together. Door_open and either motor are never high together.
- Reset mid-move or with the door open: all outputs return to reset values immediately; the car position resets to floor 0.

Optional Feature:
Macro DOOR_REOPEN_EN.
- Defined: a Floor_req bit for Current_floor seen in DOOR_OPEN restarts door timing. The FSM goes to DOOR_CLOSE for 1 cycle, then straight back to DOOR_OPEN (not via IDLE). The request bit is not latched.
- Undefined: such a request is latched into Req_pending and served on the next IDLE pass (door reopens after the close cycle via IDLE).

Decomposition:
- Package lift_pkg holds:
  - the state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_CLOSE);
  - the direction enum;
  - default NUM_FLOORS and TRAVEL_CYCLES constants.
- Sub-module lift_travel_timer: counter with enable, clear and terminal-count pulse, parameterised by TRAVEL_CYCLES.
- The ahead/behind request scan stays inline.

Test Plan:
1. Reset, then Floor_req=8'b0000_1000 for 1 cycle -> Motor_up high for 60 cycles; Current_floor 0->3; Door_open=Enable_counter=1. Model count_over after 30 negedges -> Door_open low 1 cycle later -> IDLE; Req_pending=0.
2. Requests at floor 5 and floor 2 while moving up from 0 -> stop at 2, then 5; no direction reversal.
3. At floor 5, request floor 1 -> direction flips; Motor_down only; stop at 1.
4. count_over held at 1 when DOOR_OPEN is entered -> first cycle ignored. Then Enable_counter drops for exactly 1 cycle and does not re-rise the next cycle.
5. Reset_n low mid-move, car at floor 4 -> all outputs 0 immediately, Current_floor=0, Req_pending=0.
6. DOOR_REOPEN_EN defined, request for the current floor while the door is open -> DOOR_CLOSE for 1 cycle, then DOOR_OPEN again. Undefined -> bit set in Req_pending, door reopens via IDLE.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types and default sizing for the single-lift motion controller.
package lift_pkg;

  localparam int unsigned NUM_FLOORS_DEF    = 8;
  localparam int unsigned FLOOR_W_DEF       = 3;
  localparam int unsigned TRAVEL_CYCLES_DEF = 20;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MOVE_UP    = 3'd1,
    MOVE_DOWN  = 3'd2,
    DOOR_OPEN  = 3'd3,
    DOOR_CLOSE = 3'd4
  } lift_state_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } lift_dir_e;

endpackage

// File: rtl/lift_motion_ctrl_if.sv
// Door-timer handshake: the controller enables the timer, the timer reports expiry.
interface lift_motion_ctrl_if;

  logic Enable_counter;
  logic count_over;

  modport master (output Enable_counter, input count_over);
  modport slave  (input Enable_counter, output count_over);

endinterface

// File: rtl/lift_travel_timer.sv
// Per-floor travel counter: counts 0..TRAVEL_CYCLES-1 while enabled, pulses at terminal count.
module lift_travel_timer #(
  parameter int unsigned TRAVEL_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_c
);

  localparam int unsigned CNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_c = en_i && (cnt_q == CNT_W'(TRAVEL_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_c) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lift_motion_ctrl.sv
// Single-lift controller: latches floor requests, moves one floor at a time, runs the door timer.
// Optional DOOR_REOPEN_EN: a current-floor request while the door is open restarts door timing.
module lift_motion_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = NUM_FLOORS_DEF,
  parameter int unsigned FLOOR_W       = FLOOR_W_DEF,
  parameter int unsigned TRAVEL_CYCLES = TRAVEL_CYCLES_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [NUM_FLOORS-1:0] Floor_req,
  lift_motion_ctrl_if.master    door_if,
  output logic [FLOOR_W-1:0]    Current_floor,
  output logic                  Motor_up,
  output logic                  Motor_down,
  output logic                  Door_open,
  output logic [NUM_FLOORS-1:0] Req_pending
);

  lift_state_e           state_q, state_d;
  lift_dir_e             dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [NUM_FLOORS-1:0] req_q, req_d;
  logic                  first_q, first_d;
  logic                  motor_up_q, motor_up_d;
  logic                  motor_dn_q, motor_dn_d;
  logic                  door_q, door_d;
  logic                  en_q, en_d;

  logic                  moving;
  logic                  travel_tc;
  logic [FLOOR_W-1:0]    nxt_floor;
  logic                  here_pend, above_cur, below_cur;
  logic                  nxt_pend, above_nxt, below_nxt;
  logic                  ahead, behind;
  logic [NUM_FLOORS-1:0] tgt_onehot;
  logic [NUM_FLOORS-1:0] set_v;

`ifdef DOOR_REOPEN_EN
  logic reopen_q, reopen_d;
  logic reopen_hit;
`endif

  assign moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign nxt_floor = (state_q == MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);

  lift_travel_timer #(
    .TRAVEL_CYCLES(TRAVEL_CYCLES)
  ) u_travel_timer (
    .clk   (Clock),
    .rst_n (Reset_n),
    .en_i  (moving),
    .clr_i (!moving),
    .tc_c  (travel_tc)
  );

  // Request scan relative to the current floor and to the floor about to be reached.
  always_comb begin
    here_pend = 1'b0;
    above_cur = 1'b0;
    below_cur = 1'b0;
    nxt_pend  = 1'b0;
    above_nxt = 1'b0;
    below_nxt = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      here_pend = here_pend | (req_q[i] & (FLOOR_W'(i) == floor_q));
      above_cur = above_cur | (req_q[i] & (FLOOR_W'(i) > floor_q));
      below_cur = below_cur | (req_q[i] & (FLOOR_W'(i) < floor_q));
      nxt_pend  = nxt_pend  | (req_q[i] & (FLOOR_W'(i) == nxt_floor));
      above_nxt = above_nxt | (req_q[i] & (FLOOR_W'(i) > nxt_floor));
      below_nxt = below_nxt | (req_q[i] & (FLOOR_W'(i) < nxt_floor));
    end
    ahead  = (dir_q == DIR_UP) ? above_cur : below_cur;
    behind = (dir_q == DIR_UP) ? below_cur : above_cur;
  end

`ifdef DOOR_REOPEN_EN
  always_comb begin
    reopen_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      reopen_hit = reopen_hit | (Floor_req[i] & (FLOOR_W'(i) == floor_q));
    end
  end
`endif

  // State register, request latch and registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      dir_q      <= DIR_UP;
      floor_q    <= '0;
      req_q      <= '0;
      first_q    <= 1'b0;
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
      door_q     <= 1'b0;
      en_q       <= 1'b0;
`ifdef DOOR_REOPEN_EN
      reopen_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      floor_q    <= floor_d;
      req_q      <= req_d;
      first_q    <= first_d;
      motor_up_q <= motor_up_d;
      motor_dn_q <= motor_dn_d;
      door_q     <= door_d;
      en_q       <= en_d;
`ifdef DOOR_REOPEN_EN
      reopen_q   <= reopen_d;
`endif
    end
  end

  // Next state, position, direction and pending-request update.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
`ifdef DOOR_REOPEN_EN
    reopen_d = reopen_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (here_pend) begin
          state_d = DOOR_OPEN;
        end else if (ahead) begin
          state_d = (dir_q == DIR_UP) ? MOVE_UP : MOVE_DOWN;
        end else if (behind) begin
          dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
          state_d = (dir_q == DIR_UP) ? MOVE_DOWN : MOVE_UP;
        end
      end
      MOVE_UP: begin
        if (travel_tc) begin
          floor_d = nxt_floor;
          if (nxt_pend)       state_d = DOOR_OPEN;
          else if (above_nxt) state_d = MOVE_UP;
          else                state_d = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (travel_tc) begin
          floor_d = nxt_floor;
          if (nxt_pend)       state_d = DOOR_OPEN;
          else if (below_nxt) state_d = MOVE_DOWN;
          else                state_d = IDLE;
        end
      end
      DOOR_OPEN: begin
`ifdef DOOR_REOPEN_EN
        if (reopen_hit) begin
          state_d  = DOOR_CLOSE;
          reopen_d = 1'b1;
        end else
`endif
        if (!first_q && door_if.count_over) begin
          state_d = DOOR_CLOSE;
        end
      end
      DOOR_CLOSE: begin
`ifdef DOOR_REOPEN_EN
        if (reopen_q) begin
          state_d  = DOOR_OPEN;
          reopen_d = 1'b0;
        end else
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      tgt_onehot[i] = (FLOOR_W'(i) == floor_d);
    end
    // First DOOR_OPEN cycle arms the stale count_over guard and clears the served floor.
    first_d = (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);
    set_v   = Floor_req;
`ifdef DOOR_REOPEN_EN
    if ((state_q == DOOR_OPEN) || (state_d == DOOR_OPEN)) begin
      set_v = Floor_req & ~tgt_onehot;
    end
`endif
    req_d = (req_q & ~(first_d ? tgt_onehot : '0)) | set_v;
  end

  // Actuator outputs follow the next state so they change on the same edge as the state.
  always_comb begin
    motor_up_d = (state_d == MOVE_UP);
    motor_dn_d = (state_d == MOVE_DOWN);
    door_d     = (state_d == DOOR_OPEN);
    en_d       = (state_d == DOOR_OPEN);
  end

  assign Current_floor          = floor_q;
  assign Req_pending            = req_q;
  assign Motor_up               = motor_up_q;
  assign Motor_down             = motor_dn_q;
  assign Door_open              = door_q;
  assign door_if.Enable_counter = en_q;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Directed bench for lift_motion_ctrl with a 30-negedge door-timer model.
module tb_lift_motion_ctrl;

  logic       Clock;
  logic       Reset_n;
  logic [7:0] Floor_req;
  logic [2:0] Current_floor;
  logic       Motor_up, Motor_down, Door_open;
  logic [7:0] Req_pending;
  logic       co_model, co_force;
  int         tcnt;
  int         errors = 0;
  int         checks = 0;

  lift_motion_ctrl_if dif ();

  lift_motion_ctrl #(
    .NUM_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYCLES(20)
  ) dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .Floor_req     (Floor_req),
    .door_if       (dif),
    .Current_floor (Current_floor),
    .Motor_up      (Motor_up),
    .Motor_down    (Motor_down),
    .Door_open     (Door_open),
    .Req_pending   (Req_pending)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign dif.count_over = co_model | co_force;

  // External door timer: expires after 30 negedges with enable high, clears when enable is low.
  always @(negedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tcnt     <= 0;
      co_model <= 1'b0;
    end else if (!dif.Enable_counter) begin
      tcnt     <= 0;
      co_model <= 1'b0;
    end else begin
      if (tcnt < 30) tcnt <= tcnt + 1;
      if (tcnt + 1 >= 30) co_model <= 1'b1;
    end
  end

  function automatic logic sel(input int s);
    case (s)
      0:       return Motor_up;
      1:       return Motor_down;
      default: return Door_open;
    endcase
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic count_high(input int s, input int limit, output int n);
    n = 0;
    while (sel(s) === 1'b1 && n < limit) begin
      n++;
      step();
    end
  endtask

  task automatic do_reset();
    Floor_req = '0;
    co_force  = 1'b0;
    Reset_n   = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    Floor_req = '0;
    co_force  = 1'b0;
    Reset_n   = 1'b0;
    #13;
    checks++;
    if ({Motor_up, Motor_down, Door_open, dif.Enable_counter, Current_floor, Req_pending} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got up=%b dn=%b door=%b en=%b floor=%0d req=%h, want all 0",
               Motor_up, Motor_down, Door_open, dif.Enable_counter, Current_floor, Req_pending);
    end
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({Motor_up, Motor_down, Door_open, dif.Enable_counter} !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle_hold: got up=%b dn=%b door=%b en=%b, want 0000",
               Motor_up, Motor_down, Door_open, dif.Enable_counter);
    end
  endtask

  task automatic test_single_trip();
    int n;
    do_reset();
    Floor_req = 8'h08;
    step();
    Floor_req = '0;
    checks++;
    if (Req_pending !== 8'h08 || Motor_up !== 1'b0) begin
      errors++;
      $display("FAIL trip_latch: got req=%h up=%b, want req=08 up=0", Req_pending, Motor_up);
    end
    step();
    count_high(0, 200, n);
    checks++;
    if (n !== 60) begin
      errors++;
      $display("FAIL trip_motor_cycles: got %0d, want 60", n);
    end
    checks++;
    if (Current_floor !== 3'd3 || Door_open !== 1'b1 || dif.Enable_counter !== 1'b1 || Req_pending !== 8'h00) begin
      errors++;
      $display("FAIL trip_arrive: got floor=%0d door=%b en=%b req=%h, want 3 1 1 00",
               Current_floor, Door_open, dif.Enable_counter, Req_pending);
    end
    count_high(2, 100, n);
    checks++;
    if (n !== 30) begin
      errors++;
      $display("FAIL trip_door_cycles: got %0d, want 30", n);
    end
    step();
    checks++;
    if ({Door_open, dif.Enable_counter, Motor_up, Motor_down, dif.count_over} !== 5'b0) begin
      errors++;
      $display("FAIL trip_idle_after_close: got door=%b en=%b up=%b dn=%b co=%b, want 00000",
               Door_open, dif.Enable_counter, Motor_up, Motor_down, dif.count_over);
    end
  endtask

  task automatic test_two_stops();
    int n;
    do_reset();
    Floor_req = 8'h20;
    step();
    Floor_req = '0;
    step();
    repeat (5) step();
    Floor_req = 8'h04;
    step();
    Floor_req = '0;
    count_high(0, 200, n);
    checks++;
    if (n !== 34) begin
      errors++;
      $display("FAIL two_stops_first_leg: got %0d motor cycles after 7, want 34", n);
    end
    checks++;
    if (Current_floor !== 3'd2 || Door_open !== 1'b1 || Req_pending !== 8'h20) begin
      errors++;
      $display("FAIL two_stops_at2: got floor=%0d door=%b req=%h, want 2 1 20",
               Current_floor, Door_open, Req_pending);
    end
    count_high(2, 100, n);
    step();
    step();
    checks++;
    if (Motor_up !== 1'b1 || Motor_down !== 1'b0) begin
      errors++;
      $display("FAIL two_stops_resume_up: got up=%b dn=%b, want 1 0", Motor_up, Motor_down);
    end
    count_high(0, 200, n);
    checks++;
    if (n !== 60 || Current_floor !== 3'd5 || Door_open !== 1'b1 || Req_pending !== 8'h00) begin
      errors++;
      $display("FAIL two_stops_at5: got cycles=%0d floor=%0d door=%b req=%h, want 60 5 1 00",
               n, Current_floor, Door_open, Req_pending);
    end
  endtask

  task automatic test_reverse();
    int n;
    repeat (3) step();
    Floor_req = 8'h02;
    step();
    Floor_req = '0;
    checks++;
    if (Req_pending !== 8'h02 || Door_open !== 1'b1) begin
      errors++;
      $display("FAIL reverse_latch: got req=%h door=%b, want 02 1", Req_pending, Door_open);
    end
    count_high(2, 100, n);
    step();
    step();
    checks++;
    if (Motor_down !== 1'b1 || Motor_up !== 1'b0) begin
      errors++;
      $display("FAIL reverse_motor_down: got up=%b dn=%b, want 0 1", Motor_up, Motor_down);
    end
    count_high(1, 300, n);
    checks++;
    if (n !== 80 || Current_floor !== 3'd1 || Door_open !== 1'b1 || Req_pending !== 8'h00) begin
      errors++;
      $display("FAIL reverse_at1: got cycles=%0d floor=%0d door=%b req=%h, want 80 1 1 00",
               n, Current_floor, Door_open, Req_pending);
    end
    count_high(2, 100, n);
    step();
  endtask

  task automatic test_stale_guard();
    co_force  = 1'b1;
    Floor_req = 8'h02;
    step();
    Floor_req = '0;
    checks++;
    if (Door_open !== 1'b0 || Req_pending !== 8'h02) begin
      errors++;
      $display("FAIL stale_idle: got door=%b req=%h, want 0 02", Door_open, Req_pending);
    end
    step();
    checks++;
    if (Door_open !== 1'b1 || dif.Enable_counter !== 1'b1) begin
      errors++;
      $display("FAIL stale_entry: got door=%b en=%b, want 1 1", Door_open, dif.Enable_counter);
    end
    step();
    checks++;
    if (Door_open !== 1'b1 || dif.Enable_counter !== 1'b1) begin
      errors++;
      $display("FAIL stale_guard_cycle: got door=%b en=%b, want 1 1", Door_open, dif.Enable_counter);
    end
    step();
    co_force = 1'b0;
    checks++;
    if (Door_open !== 1'b0 || dif.Enable_counter !== 1'b0) begin
      errors++;
      $display("FAIL stale_close: got door=%b en=%b, want 0 0", Door_open, dif.Enable_counter);
    end
    step();
    checks++;
    if (dif.Enable_counter !== 1'b0) begin
      errors++;
      $display("FAIL stale_no_rerise1: got en=%b, want 0", dif.Enable_counter);
    end
    step();
    checks++;
    if (dif.Enable_counter !== 1'b0 || Door_open !== 1'b0) begin
      errors++;
      $display("FAIL stale_no_rerise2: got en=%b door=%b, want 0 0", dif.Enable_counter, Door_open);
    end
  endtask

  task automatic test_reset_mid_move();
    bit ok;
    do_reset();
    Floor_req = 8'h40;
    step();
    Floor_req = '0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (Current_floor === 3'd4) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midmove_reach4: got floor=%0d, want 4 within 200 cycles", Current_floor);
    end
    repeat (5) step();
    checks++;
    if (Motor_up !== 1'b1 || Current_floor !== 3'd4) begin
      errors++;
      $display("FAIL midmove_moving: got up=%b floor=%0d, want 1 4", Motor_up, Current_floor);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({Motor_up, Motor_down, Door_open, dif.Enable_counter, Current_floor, Req_pending} !== 15'h0) begin
      errors++;
      $display("FAIL midmove_async_reset: got up=%b dn=%b door=%b en=%b floor=%0d req=%h, want all 0",
               Motor_up, Motor_down, Door_open, dif.Enable_counter, Current_floor, Req_pending);
    end
    @(posedge Clock);
    #1 Reset_n = 1'b1;
    repeat (2) step();
    checks++;
    if (Motor_up !== 1'b0 || Req_pending !== 8'h00) begin
      errors++;
      $display("FAIL midmove_after_release: got up=%b req=%h, want 0 00", Motor_up, Req_pending);
    end
  endtask

  task automatic test_door_reopen();
    int n;
    do_reset();
    Floor_req = 8'h01;
    step();
    Floor_req = '0;
    step();
    checks++;
    if (Door_open !== 1'b1 || Current_floor !== 3'd0) begin
      errors++;
      $display("FAIL reopen_first_open: got door=%b floor=%0d, want 1 0", Door_open, Current_floor);
    end
    repeat (2) step();
    Floor_req = 8'h01;
    step();
    Floor_req = '0;
`ifdef DOOR_REOPEN_EN
    checks++;
    if (Door_open !== 1'b0 || dif.Enable_counter !== 1'b0 || Req_pending !== 8'h00) begin
      errors++;
      $display("FAIL reopen_close_cycle: got door=%b en=%b req=%h, want 0 0 00",
               Door_open, dif.Enable_counter, Req_pending);
    end
    step();
    checks++;
    if (Door_open !== 1'b1 || dif.Enable_counter !== 1'b1) begin
      errors++;
      $display("FAIL reopen_direct: got door=%b en=%b, want 1 1", Door_open, dif.Enable_counter);
    end
    count_high(2, 100, n);
    checks++;
    if (n !== 30) begin
      errors++;
      $display("FAIL reopen_restart_len: got %0d, want 30", n);
    end
`else
    checks++;
    if (Door_open !== 1'b1 || Req_pending !== 8'h01) begin
      errors++;
      $display("FAIL reopen_latched: got door=%b req=%h, want 1 01", Door_open, Req_pending);
    end
    count_high(2, 100, n);
    step();
    checks++;
    if (Door_open !== 1'b0 || dif.Enable_counter !== 1'b0) begin
      errors++;
      $display("FAIL reopen_via_idle_gap: got door=%b en=%b, want 0 0", Door_open, dif.Enable_counter);
    end
    step();
    checks++;
    if (Door_open !== 1'b1 || Req_pending !== 8'h00) begin
      errors++;
      $display("FAIL reopen_via_idle: got door=%b req=%h, want 1 00", Door_open, Req_pending);
    end
    count_high(2, 100, n);
`endif
  endtask

  initial begin
    Reset_n   = 1'b0;
    Floor_req = '0;
    co_force  = 1'b0;
    test_reset();
    test_single_trip();
    test_two_stops();
    test_reverse();
    test_stale_guard();
    test_reset_mid_move();
    test_door_reopen();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
